// File: rtl/iter_divider_64.sv
// iter_divider_64
//   Multi-cycle restoring divider for RV64 DIV/DIVU/REM/REMU.
//   Each CALC cycle retires one quotient bit. The unsigned core works on
//   operand magnitudes, and the result signs are fixed up on the final step.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : request pulse, sampled only while ready=1
//   is_signed    : 1 = DIV/REM (two's complement), 0 = DIVU/REMU
//   dividend     : numerator, captured on an accepted start
//   divisor      : denominator, captured on an accepted start
//   ready        : idle, a start will be accepted
//   done         : one-cycle pulse, results valid
//   quotient     : registered quotient
//   remainder    : registered remainder
//   div_by_zero  : registered flag, divisor was zero for the last completed op
//
// Handshake: a request is accepted on any rising edge where start=1 and
// ready=1. Exactly one done pulse follows each accepted request, unless rst
// intervenes. Result registers only change at completion, so they stay stable
// from one done pulse until the next.
module iter_divider_64 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  // Working registers.
  // quo_q starts as |dividend|. It shifts left each step, and the quotient
  // bits enter at the LSB.
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_mag;
  logic [CW-1:0]   count;
  logic            neg_q;
  logic            neg_r;

  // Request decode
  logic            sign_a, sign_b;
  logic            div_zero, sgn_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b;

  assign sign_a   = is_signed & dividend[XLEN-1];
  assign sign_b   = is_signed & divisor[XLEN-1];
  assign abs_a    = sign_a ? (~dividend + 1'b1) : dividend;
  assign abs_b    = sign_b ? (~divisor + 1'b1) : divisor;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor == '1);
  assign special  = div_zero | sgn_ovf;

  // One restoring step.
  // The trial value is XLEN+1 bits wide. The subtract uses one more guard bit,
  // so its MSB is a clean borrow.
  logic [XLEN:0]   trial;
  logic [XLEN+1:0] diff;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, q_fin, r_fin;
  logic            last_step;

  assign trial     = {rem_q, quo_q[XLEN-1]};
  assign diff      = {1'b0, trial} - {2'b00, div_mag};
  assign ge        = ~diff[XLEN+1];
  // After a successful subtract the result is below div_mag, so it fits in
  // XLEN bits. After a failed one, trial itself is below div_mag.
  assign rem_step  = ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_step  = {quo_q[XLEN-2:0], ge};
  // Negating zero yields zero, so no negative zero can appear.
  assign q_fin     = neg_q ? (~quo_step + 1'b1) : quo_step;
  assign r_fin     = neg_r ? (~rem_step + 1'b1) : rem_step;
  assign last_step = (state == CALC) && (count == CW'(1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state and outputs
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        if (count == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q       <= '0;
      rem_q       <= '0;
      div_mag     <= '0;
      count       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (sgn_ovf) begin
              quotient    <= dividend;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quo_q   <= abs_a;
              rem_q   <= '0;
              div_mag <= abs_b;
              count   <= CW'(XLEN);
              neg_q   <= sign_a ^ sign_b;
              neg_r   <= sign_a;
            end
          end
        end
        CALC: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          count <= count - 1'b1;
          if (last_step) begin
            quotient    <= q_fin;
            remainder   <= r_fin;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider_64.sv
module tb_iter_divider_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        ready;
  logic        done;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  // Last completed result, expected to hold through the next CALC.
  logic [63:0] last_q = '0;

  iter_divider_64 #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request in cycle k and follow it to its done pulse.
  // glitch_at > 0 raises start again in that cycle after acceptance.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_q, input logic [63:0] exp_r,
                        input logic exp_dz, input int exp_lat, input int glitch_at);
    int   lat;
    logic ready_leak;
    @(negedge clk);
    check({tag, " ready_idle"}, {63'b0, ready}, 64'd1);
    check({tag, " done_idle"}, {63'b0, done}, 64'd0);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    // Operands change after acceptance and must be ignored.
    dividend   = ~a;
    divisor    = b + 64'd3;
    is_signed  = ~sgn;
    lat        = 1;
    ready_leak = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (ready !== 1'b0) ready_leak = 1'b1;
      if (lat == 3) check({tag, " hold_q"}, quotient, last_q);
      start = (lat == glitch_at);
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (ready !== 1'b0) ready_leak = 1'b1;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " ready_low"}, {63'b0, ready_leak}, 64'd0);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " remainder"}, remainder, exp_r);
    check({tag, " div_by_zero"}, {63'b0, div_by_zero}, {63'b0, exp_dz});
    last_q = exp_q;
  endtask

  initial begin
    int done_cnt;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst ready", {63'b0, ready}, 64'd1);
    check("rst done", {63'b0, done}, 64'd0);
    check("rst quotient", quotient, 64'd0);
    check("rst remainder", remainder, 64'd0);
    check("rst div_by_zero", {63'b0, div_by_zero}, 64'd0);
    rst = 1'b0;

    // Unsigned
    run_op("u100_7", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 0);
    // Signed
    run_op("s-7_2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65, 0);
    run_op("s7_-2", 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 65, 0);
    run_op("s-100_-7", 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
           64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65, 0);
    // Divide by zero
    run_op("u42_0", 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1'b1, 1, 0);
    run_op("s42_0", 1'b1, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 1'b1, 1, 0);
    // Signed overflow and its unsigned counterpart
    run_op("s_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 64'd0, 1'b0, 1, 0);
    run_op("u_ovf", 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 64'h8000_0000_0000_0000, 1'b0, 65, 0);
    // Boundaries
    run_op("u_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
           64'd1, 64'd1, 1'b0, 65, 0);
    run_op("u0_5", 1'b0, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 65, 0);
    // A start raised during CALC is ignored
    run_op("glitch", 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 1'b0, 65, 10);

    // Reset in the middle of CALC
    @(negedge clk);
    check("abort ready_idle", {63'b0, ready}, 64'd1);
    is_signed = 1'b0;
    dividend  = 64'd100;
    divisor   = 64'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort ready", {63'b0, ready}, 64'd1);
    check("abort done", {63'b0, done}, 64'd0);
    check("abort quotient", quotient, 64'd0);
    check("abort remainder", remainder, 64'd0);
    done_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort no_done", 64'(done_cnt), 64'd0);
    last_q = '0;

    // Still works after the abort
    run_op("post_rst", 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
